// File: rtl/disp_hex_mux_n_pkg.sv
// rtl/disp_hex_mux_n_pkg.sv - shared seven-segment definitions for the display mux
package disp_hex_mux_n_pkg;

    typedef logic [6:0] sseg_t;

    // Active-low segments, so all ones is a dark digit.
    localparam sseg_t SSEG_BLANK = 7'h7F;

    localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/hex_to_sseg.sv
// rtl/hex_to_sseg.sv - combinational hex nibble to active-low {a..g} segment decode
module hex_to_sseg
    import disp_hex_mux_n_pkg::*;
(
    input  logic [3:0] i_hex,
    output sseg_t      o_sseg
);

    always_comb begin
        o_sseg = SSEG_BLANK;
        case (i_hex)
            4'h0: o_sseg = 7'h01;
            4'h1: o_sseg = 7'h4F;
            4'h2: o_sseg = 7'h12;
            4'h3: o_sseg = 7'h06;
            4'h4: o_sseg = 7'h4C;
            4'h5: o_sseg = 7'h24;
            4'h6: o_sseg = 7'h20;
            4'h7: o_sseg = 7'h0F;
            4'h8: o_sseg = 7'h00;
            4'h9: o_sseg = 7'h04;
            4'hA: o_sseg = 7'h08;
            4'hB: o_sseg = 7'h60;
            4'hC: o_sseg = 7'h31;
            4'hD: o_sseg = 7'h42;
            4'hE: o_sseg = 7'h30;
            4'hF: o_sseg = 7'h38;
            default: o_sseg = SSEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_hex_mux_n.sv
// rtl/disp_hex_mux_n.sv - time-multiplexed common-anode hex display driver
module disp_hex_mux_n
    import disp_hex_mux_n_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 62500,
    parameter int GUARD_CYCLES = 64,
    parameter int BRIGHT_BITS  = 3,
    parameter int BLINK_FRAMES = 200
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4*DIGITS-1:0]    hex,
    input  logic [DIGITS-1:0]      dp_in,
    input  logic [DIGITS-1:0]      digit_en,
    input  logic [DIGITS-1:0]      blink,
    input  logic                   blank_lz,
    input  logic [BRIGHT_BITS-1:0] bright,
    output logic [DIGITS-1:0]      an,
    output logic [6:0]             sseg,
    output logic                   dp,
    output logic                   frame_tick
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int FRM_W  = $clog2(BLINK_FRAMES + 1);

    logic [SLOT_W-1:0]      r_slot_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [BRIGHT_BITS-1:0] r_pwm_cnt;
    logic [FRM_W-1:0]       r_frame_cnt;
    logic                   r_blink_phase;

    logic [4*DIGITS-1:0]    r_hex;
    logic [DIGITS-1:0]      r_dp;
    logic [DIGITS-1:0]      r_en;
    logic [DIGITS-1:0]      r_blink;
    logic                   r_blank_lz;

    logic [DIGITS-1:0]      r_an;
    sseg_t                  r_sseg;
    logic                   r_dp_out;
    logic                   r_frame_tick;

    logic                   w_slot_end;
    logic                   w_wrap;
    logic [3:0]             w_digit;
    sseg_t                  w_sseg;
    logic [DIGITS-1:0]      w_lz_blank;
    logic                   w_zero_above;
    logic                   w_lit;
    logic                   w_on;
    logic [DIGITS-1:0]      w_an_sel;

    assign w_slot_end = (r_slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
    assign w_wrap     = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
    assign w_digit    = r_hex[{r_idx, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .i_hex  (w_digit),
        .o_sseg (w_sseg)
    );

    // Scan from the most significant digit down; digit 0 is never blanked.
    always_comb begin
        w_lz_blank   = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_lz_blank[i] = r_blank_lz && w_zero_above && (r_hex[4*i +: 4] == 4'h0);
            w_zero_above  = w_zero_above && (r_hex[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        w_an_sel        = '1;
        w_an_sel[r_idx] = 1'b0;
    end

    assign w_lit = r_en[r_idx] && !w_lz_blank[r_idx] && !(r_blink[r_idx] && r_blink_phase);
    assign w_on  = w_lit && (r_slot_cnt >= SLOT_W'(GUARD_CYCLES)) && (r_pwm_cnt <= bright);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt    <= '0;
            r_idx         <= '0;
            r_pwm_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_hex         <= '0;
            r_dp          <= '0;
            r_en          <= '0;
            r_blink       <= '0;
            r_blank_lz    <= 1'b0;
            r_an          <= '1;
            r_sseg        <= SSEG_BLANK;
            r_dp_out      <= 1'b1;
            r_frame_tick  <= 1'b0;
        end else begin
            r_pwm_cnt    <= r_pwm_cnt + 1'b1;
            r_frame_tick <= w_wrap;

            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_idx      <= w_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            // Inputs only take effect at frame boundaries so a scan never tears.
            if (w_wrap) begin
                r_hex      <= hex;
                r_dp       <= dp_in;
                r_en       <= digit_en;
                r_blink    <= blink;
                r_blank_lz <= blank_lz;
                if (r_frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end

            r_an     <= w_on ? w_an_sel : '1;
            r_sseg   <= w_lit ? w_sseg : SSEG_BLANK;
            r_dp_out <= w_lit ? ~r_dp[r_idx] : 1'b1;
        end
    end

    assign an         = r_an;
    assign sseg       = r_sseg;
    assign dp         = r_dp_out;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_disp_hex_mux_n.sv
// tb/tb_disp_hex_mux_n.sv - directed self-checking bench for disp_hex_mux_n
module tb_disp_hex_mux_n;

    localparam int SLOT  = 80;
    localparam int GUARD = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] hex;
    logic [3:0]  dp_in, digit_en, blink;
    logic        blank_lz;
    logic [2:0]  bright;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp, frame_tick;

    logic [31:0] hex8;
    logic [7:0]  dp8, en8, blink8;
    logic        blz8;
    logic [2:0]  bright8;
    logic [7:0]  an8;
    logic [6:0]  sseg8;
    logic        dpo8, tick8;

    int n_cmp = 0;
    int n_err = 0;
    int pos   = 0;

    disp_hex_mux_n #(
        .DIGITS(4), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD),
        .BRIGHT_BITS(3), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .hex(hex), .dp_in(dp_in),
        .digit_en(digit_en), .blink(blink), .blank_lz(blank_lz), .bright(bright),
        .an(an), .sseg(sseg), .dp(dp), .frame_tick(frame_tick)
    );

    disp_hex_mux_n #(
        .DIGITS(8), .SLOT_CYCLES(4), .GUARD_CYCLES(1),
        .BRIGHT_BITS(3), .BLINK_FRAMES(2)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .hex(hex8), .dp_in(dp8),
        .digit_en(en8), .blink(blink8), .blank_lz(blz8), .bright(bright8),
        .an(an8), .sseg(sseg8), .dp(dpo8), .frame_tick(tick8)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic goto_slot(input int d, input int s);
        int t;
        t = 1 + d * SLOT + s;
        step(t - pos);
        pos = t;
    endtask

    task automatic wait_frame(output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            n++;
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
        pos = 0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_sync: no frame_tick within %0d cycles, required one", n);
        end
    endtask

    task automatic test_reset();
        step(3);
        n_cmp++; if (an !== 4'hF)     begin n_err++; $display("FAIL rst_an: got %h want F", an); end
        n_cmp++; if (sseg !== 7'h7F)  begin n_err++; $display("FAIL rst_sseg: got %h want 7F", sseg); end
        n_cmp++; if (dp !== 1'b1)     begin n_err++; $display("FAIL rst_dp: got %b want 1", dp); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b want 0", frame_tick); end
        n_cmp++; if (an8 !== 8'hFF)   begin n_err++; $display("FAIL rst_an8: got %h want FF", an8); end
        reset_n = 1'b1;
        step(41);
        n_cmp++; if (an !== 4'hF)     begin n_err++; $display("FAIL first_frame_dark: got %h want F", an); end
    endtask

    task automatic test_scan();
        int n;
        logic [6:0] exp_s [4];
        logic [3:0] e_an;
        exp_s = '{7'h38, 7'h08, 7'h12, 7'h4F};
        wait_frame(n);
        goto_slot(0, 0);
        n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL guard_start: got %h want F", an); end
        goto_slot(0, GUARD - 1);
        n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL guard_last: got %h want F", an); end
        goto_slot(0, GUARD);
        n_cmp++; if (an !== 4'hE) begin n_err++; $display("FAIL guard_end: got %h want E", an); end
        for (int d = 0; d < 4; d++) begin
            goto_slot(d, 40);
            e_an = ~(4'b0001 << d);
            n_cmp++; if (an !== e_an) begin n_err++; $display("FAIL scan_an d%0d: got %h want %h", d, an, e_an); end
            n_cmp++; if (sseg !== exp_s[d]) begin n_err++; $display("FAIL scan_sseg d%0d: got %h want %h", d, sseg, exp_s[d]); end
            n_cmp++; if (dp !== (d != 2)) begin n_err++; $display("FAIL scan_dp d%0d: got %b want %b", d, dp, d != 2); end
        end
    endtask

    task automatic test_lz();
        int n;
        blank_lz = 1'b1;
        hex      = 16'h0040;
        dp_in    = 4'b0000;
        wait_frame(n);
        goto_slot(0, 40);
        n_cmp++; if (an !== 4'hE || sseg !== 7'h01) begin n_err++; $display("FAIL lz_d0: got an=%h sseg=%h want E/01", an, sseg); end
        goto_slot(1, 40);
        n_cmp++; if (an !== 4'hD || sseg !== 7'h4C) begin n_err++; $display("FAIL lz_d1: got an=%h sseg=%h want D/4C", an, sseg); end
        goto_slot(2, 40);
        n_cmp++; if (an !== 4'hF || sseg !== 7'h7F) begin n_err++; $display("FAIL lz_d2: got an=%h sseg=%h want F/7F", an, sseg); end
        goto_slot(3, 40);
        n_cmp++; if (an !== 4'hF || sseg !== 7'h7F || dp !== 1'b1) begin n_err++; $display("FAIL lz_d3: got an=%h sseg=%h dp=%b want F/7F/1", an, sseg, dp); end
        hex = 16'h0000;
        wait_frame(n);
        goto_slot(0, 40);
        n_cmp++; if (an !== 4'hE || sseg !== 7'h01) begin n_err++; $display("FAIL lz_zero_d0: got an=%h sseg=%h want E/01", an, sseg); end
        goto_slot(1, 40);
        n_cmp++; if (an !== 4'hF) begin n_err++; $display("FAIL lz_zero_d1: got %h want F", an); end
    endtask

    task automatic test_pwm();
        int n, lows_g, lows_p;
        blank_lz = 1'b0;
        hex      = 16'h12AF;
        bright   = 3'd0;
        wait_frame(n);
        goto_slot(0, 0);
        lows_g = 0;
        lows_p = 0;
        for (int s = 0; s < GUARD; s++) begin
            if (an !== 4'hF) lows_g++;
            step(1);
            pos++;
        end
        for (int s = GUARD; s < SLOT; s++) begin
            if (an === 4'hE) lows_p++;
            step(1);
            pos++;
        end
        n_cmp++; if (lows_g != 0) begin n_err++; $display("FAIL pwm_guard: got %0d low cycles want 0", lows_g); end
        n_cmp++; if (lows_p != 8) begin n_err++; $display("FAIL pwm_duty: got %0d low cycles want 8", lows_p); end
        bright = 3'd7;
    endtask

    task automatic test_mid_frame();
        int n;
        hex = 16'h12AF;
        wait_frame(n);
        goto_slot(1, 40);
        hex = 16'h3456;
        goto_slot(2, 40);
        n_cmp++; if (sseg !== 7'h12) begin n_err++; $display("FAIL hold_d2: got %h want 12", sseg); end
        goto_slot(3, 40);
        n_cmp++; if (sseg !== 7'h4F) begin n_err++; $display("FAIL hold_d3: got %h want 4F", sseg); end
        wait_frame(n);
        goto_slot(0, 40);
        n_cmp++; if (sseg !== 7'h20) begin n_err++; $display("FAIL new_d0: got %h want 20", sseg); end
        goto_slot(1, 40);
        n_cmp++; if (sseg !== 7'h24) begin n_err++; $display("FAIL new_d1: got %h want 24", sseg); end
        goto_slot(2, 40);
        n_cmp++; if (an !== 4'hB) begin n_err++; $display("FAIL pre_rst_an: got %h want B", an); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (an !== 4'hF || sseg !== 7'h7F || dp !== 1'b1) begin n_err++; $display("FAIL async_rst: got an=%h sseg=%h dp=%b want F/7F/1", an, sseg, dp); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_frame(n);
        n_cmp++; if (n != 4 * SLOT) begin n_err++; $display("FAIL restart_len: got %0d cycles want %0d", n, 4 * SLOT); end
    endtask

    task automatic test_blink();
        int n;
        logic [5:0] pat;
        logic [3:0] e_an;
        pat      = 6'b011001;
        reset_n  = 1'b0;
        blink    = 4'b0001;
        hex      = 16'h12AF;
        digit_en = 4'hF;
        bright   = 3'd7;
        blank_lz = 1'b0;
        step(2);
        reset_n = 1'b1;
        for (int f = 0; f < 6; f++) begin
            wait_frame(n);
            goto_slot(0, 40);
            e_an = pat[f] ? 4'hE : 4'hF;
            n_cmp++; if (an !== e_an) begin n_err++; $display("FAIL blink_d0 f%0d: got %h want %h", f, an, e_an); end
            goto_slot(1, 40);
            n_cmp++; if (an !== 4'hD) begin n_err++; $display("FAIL blink_d1 f%0d: got %h want D", f, an); end
        end
        blink = 4'b0000;
    endtask

    task automatic test_wide();
        int last, multi, bad_s7, ticks;
        logic [7:0] seen;
        last   = -1;
        multi  = 0;
        bad_s7 = 0;
        ticks  = 0;
        seen   = 8'h00;
        for (int c = 0; c < 200; c++) begin
            step(1);
            if ($countones(~an8) > 1) multi++;
            seen = seen | ~an8;
            if (an8 === 8'h7F && sseg8 !== 7'h0F) bad_s7++;
            if (tick8) begin
                ticks++;
                if (last >= 0) begin
                    n_cmp++; if (c - last != 32) begin n_err++; $display("FAIL wide_tick_gap: got %0d want 32", c - last); end
                end
                last = c;
            end
        end
        n_cmp++; if (ticks < 6) begin n_err++; $display("FAIL wide_ticks: got %0d want >=6", ticks); end
        n_cmp++; if (multi != 0) begin n_err++; $display("FAIL wide_multi_anode: got %0d cycles want 0", multi); end
        n_cmp++; if (seen !== 8'hFF) begin n_err++; $display("FAIL wide_seen: got %h want FF", seen); end
        n_cmp++; if (bad_s7 != 0) begin n_err++; $display("FAIL wide_d7_sseg: got %0d bad cycles want 0", bad_s7); end
    endtask

    initial begin
        reset_n  = 1'b0;
        hex      = 16'h12AF;
        dp_in    = 4'b0100;
        digit_en = 4'hF;
        blink    = 4'b0000;
        blank_lz = 1'b0;
        bright   = 3'd7;
        hex8     = 32'h76543210;
        dp8      = 8'h00;
        en8      = 8'hFF;
        blink8   = 8'h00;
        blz8     = 1'b0;
        bright8  = 3'd7;
        @(negedge clk);
        test_reset();
        test_scan();
        test_lz();
        test_pwm();
        test_mid_frame();
        test_blink();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
